prbs7_checker: RTL and testbench

- Serial PRBS checker directly downstream of the 7-bit Fibonacci LFSR generator (taps 7,6,3,1; polynomial x^7+x^6+x^3+x+1, period 127).
- Consumes the generator's output bit on each enabled cycle and self-synchronises to the sequence.
- Once locked, flags and counts bit errors. Drops lock when errors become too dense.
- Used as the receive-side link/BER test stage for the LFSR block.

---
 rtl/prbs7_checker.sv | 140 ++++++++++++++
 tb/tb_prbs7_checker.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// prbs7_checker: serial PRBS-7 receive checker with self-sync,
// flywheel error detection, density-based unlock and error counter.
module prbs7_checker #(
    parameter logic [6:0] TAPS       = 7'b1100101,
    parameter int          LOCK_CNT   = 16,
    parameter int          WINDOW     = 64,
    parameter int          UNLOCK_THR = 8,
    parameter int          ERR_CNT_W  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENA,
    input  logic                 DIN,
    input  logic                 CLR,
    output logic                 LOCK,
    output logic                 ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int MISS_W  = $clog2(UNLOCK_THR + 1);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LEN    = WIN_W'(WINDOW);
    localparam logic [MISS_W-1:0]  MISS_THR   = MISS_W'(UNLOCK_THR);

    typedef enum logic [1:0] {
        S_FILL,
        S_VERIFY,
        S_LOCKED
    } state_t;

    state_t               r_state;
    logic [6:0]           r_hist;
    logic [2:0]           r_fill;
    logic [MATCH_W-1:0]   r_match;
    logic [WIN_W-1:0]     r_win;
    logic [MISS_W-1:0]    r_miss;
    logic                 r_lock;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_cnt;

    logic                 w_exp;
    logic                 w_mis;
    logic [6:0]           w_hist_din;
    logic [6:0]           w_hist_exp;
    logic [MISS_W-1:0]    w_miss_nxt;
    logic [WIN_W-1:0]     w_win_nxt;
    logic                 w_cnt_sat;

    // r_hist[k-1] holds h[k]; h[1] is the newest received bit
    assign w_exp      = ^(r_hist & TAPS);
    assign w_mis      = DIN ^ w_exp;
    assign w_hist_din = {r_hist[5:0], DIN};
    assign w_hist_exp = {r_hist[5:0], w_exp};
    assign w_miss_nxt = r_miss + MISS_W'(w_mis);
    assign w_win_nxt  = r_win + WIN_W'(1);
    assign w_cnt_sat  = &r_cnt;

    assign LOCK    = r_lock;
    assign ERR     = r_err;
    assign ERR_CNT = r_cnt;

    // Sync/lock FSM with flywheel checking and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= '0;
            r_win   <= '0;
            r_miss  <= '0;
            r_lock  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (!ENA) begin
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (CLR) begin
                r_cnt <= '0;
            end
            unique case (r_state)
                S_FILL: begin
                    r_hist <= w_hist_din;
                    if (r_fill == 3'd6) begin
                        r_state <= S_VERIFY;
                        r_fill  <= '0;
                        r_match <= '0;
                    end else begin
                        r_fill <= r_fill + 3'd1;
                    end
                end
                S_VERIFY: begin
                    r_hist <= w_hist_din;
                    if (w_mis || (w_hist_din == 7'd0)) begin
                        r_state <= S_FILL;
                        r_fill  <= '0;
                    end else if (r_match == MATCH_LAST) begin
                        r_state <= S_LOCKED;
                        r_lock  <= 1'b1;
                        r_win   <= '0;
                        r_miss  <= '0;
                    end else begin
                        r_match <= r_match + MATCH_W'(1);
                    end
                end
                S_LOCKED: begin
                    // flywheel: the prediction, not DIN, feeds history
                    r_hist <= w_hist_exp;
                    if (w_mis) begin
                        r_err <= 1'b1;
                        if (!CLR && !w_cnt_sat) begin
                            r_cnt <= r_cnt + ERR_CNT_W'(1);
                        end
                    end
                    if (w_miss_nxt == MISS_THR) begin
                        r_state <= S_FILL;
                        r_lock  <= 1'b0;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_win   <= '0;
                        r_miss  <= '0;
                    end else if (w_win_nxt == WIN_LEN) begin
                        r_win  <= '0;
                        r_miss <= '0;
                    end else begin
                        r_win  <= w_win_nxt;
                        r_miss <= w_miss_nxt;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker: randomized scenario bench for prbs7_checker,
// reference stream built from the PRBS-7 recurrence.
module tb_prbs7_checker;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ENA = 1'b0;
    logic        DIN = 1'b0;
    logic        CLR = 1'b0;
    logic        lock16, err16, lock4, err4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int n_chk  = 0;
    int n_fail = 0;
    bit gq[$];

    prbs7_checker dut (
        .CLK(CLK), .RST(RST), .ENA(ENA), .DIN(DIN), .CLR(CLR),
        .LOCK(lock16), .ERR(err16), .ERR_CNT(cnt16)
    );

    prbs7_checker #(.ERR_CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ENA(ENA), .DIN(DIN), .CLR(CLR),
        .LOCK(lock4), .ERR(err4), .ERR_CNT(cnt4)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input logic ena, input logic din, input logic clr);
        ENA = ena;
        DIN = din;
        CLR = clr;
        @(posedge CLK);
        #1;
    endtask

    // random nonzero 7-bit seed emitted as the first 7 stream bits
    task automatic gen_seed();
        logic [6:0] s;
        s = 7'($urandom_range(1, 127));
        gq.delete();
        for (int i = 0; i < 7; i++) gq.push_back(s[i]);
    endtask

    // b[n] = b[n-7] ^ b[n-6] ^ b[n-3] ^ b[n-1]
    task automatic gen_bit(output logic b);
        bit nb;
        nb = gq[0] ^ gq[1] ^ gq[4] ^ gq[6];
        b  = gq.pop_front();
        gq.push_back(nb);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        RST = 1'b1;
    endtask

    task automatic lock_fresh();
        logic b;
        gen_seed();
        for (int k = 0; k < 23; k++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'($urandom), 1'b0);
            n_chk++;
            if (lock16 !== 1'b0 || err16 !== 1'b0 || cnt16 !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_hold: lock=%b err=%b cnt=%0d want 0/0/0",
                         lock16, err16, cnt16);
            end
        end
        RST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 1'($urandom), 1'b0);
            n_chk++;
            if (lock16 !== 1'b0 || err16 !== 1'b0 || cnt16 !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_idle: lock=%b err=%b cnt=%0d want 0/0/0",
                         lock16, err16, cnt16);
            end
        end
    endtask

    task automatic test_clean_lock();
        logic b;
        int   errs;
        gen_seed();
        for (int k = 1; k <= 23; k++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            n_chk++;
            if (lock16 !== (k >= 23)) begin
                n_fail++;
                $display("FAIL clean_lock bit %0d: lock=%b want %b",
                         k, lock16, (k >= 23));
            end
        end
        errs = 0;
        for (int k = 0; k < 254; k++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            if (err16 !== 1'b0) errs++;
        end
        n_chk++;
        if (errs != 0 || cnt16 !== 16'd0 || lock16 !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_run: err_cycles=%0d cnt=%0d lock=%b want 0/0/1",
                     errs, cnt16, lock16);
        end
    endtask

    task automatic test_single_error();
        logic b;
        int   n;
        int   errs;
        n = $urandom_range(3, 20);
        for (int k = 0; k < n; k++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
        end
        gen_bit(b);
        tick(1'b1, ~b, 1'b0);
        n_chk++;
        if (err16 !== 1'b1 || lock16 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_err_pulse: err=%b lock=%b want 1/1",
                     err16, lock16);
        end
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            if (err16 !== 1'b0) errs++;
        end
        n_chk++;
        if (errs != 0 || cnt16 !== 16'd1 || lock16 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_err_after: extra=%0d cnt=%0d lock=%b want 0/1/1",
                     errs, cnt16, lock16);
        end
    endtask

    task automatic test_burst();
        logic b;
        int   gap;
        do_reset();
        lock_fresh();
        n_chk++;
        if (lock16 !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_prelock: lock=%b want 1", lock16);
        end
        for (int e = 0; e < 8; e++) begin
            gap = $urandom_range(1, 7);
            for (int k = 1; k < gap; k++) begin
                gen_bit(b);
                tick(1'b1, b, 1'b0);
            end
            gen_bit(b);
            tick(1'b1, ~b, 1'b0);
            n_chk++;
            if (err16 !== 1'b1 || lock16 !== (e < 7) || cnt16 !== 16'(e + 1)) begin
                n_fail++;
                $display("FAIL burst_err %0d: err=%b lock=%b cnt=%0d want 1/%b/%0d",
                         e, err16, lock16, cnt16, (e < 7), e + 1);
            end
        end
        for (int k = 1; k <= 23; k++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            n_chk++;
            if (lock16 !== (k >= 23)) begin
                n_fail++;
                $display("FAIL relock bit %0d: lock=%b want %b",
                         k, lock16, (k >= 23));
            end
        end
        n_chk++;
        if (cnt16 !== 16'd8) begin
            n_fail++;
            $display("FAIL relock_cnt: cnt=%0d want 8", cnt16);
        end
    endtask

    task automatic test_ena_gaps();
        logic b;
        int   en_bits;
        do_reset();
        gen_seed();
        en_bits = 0;
        for (int c = 1; c <= 46; c++) begin
            if (c % 2 == 1) begin
                gen_bit(b);
                tick(1'b1, b, 1'b0);
                en_bits++;
            end else begin
                tick(1'b0, 1'($urandom), 1'b0);
            end
            n_chk++;
            if (lock16 !== (en_bits >= 23) || err16 !== 1'b0) begin
                n_fail++;
                $display("FAIL ena_gap cycle %0d: lock=%b err=%b want %b/0",
                         c, lock16, err16, (en_bits >= 23));
            end
        end
        n_chk++;
        if (cnt16 !== 16'd0) begin
            n_fail++;
            $display("FAIL ena_gap_cnt: cnt=%0d want 0", cnt16);
        end
    endtask

    task automatic test_lockup_guard();
        int seen;
        do_reset();
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (lock16 !== 1'b0) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL zero_lockup: lock high %0d cycles want 0", seen);
        end
    endtask

    task automatic test_saturation();
        logic b;
        int   off;
        do_reset();
        lock_fresh();
        for (int w = 0; w < 20; w++) begin
            off = $urandom_range(1, 64);
            for (int j = 1; j <= 64; j++) begin
                gen_bit(b);
                if (j == off) begin
                    tick(1'b1, ~b, 1'b0);
                    n_chk++;
                    if (err16 !== 1'b1 || err4 !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sat_err win %0d: err=%b err4=%b want 1/1",
                                 w, err16, err4);
                    end
                end else begin
                    tick(1'b1, b, 1'b0);
                end
            end
        end
        n_chk++;
        if (cnt16 !== 16'd20 || cnt4 !== 4'd15 || lock16 !== 1'b1 || lock4 !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate: cnt=%0d cnt4=%0d lock=%b lock4=%b want 20/15/1/1",
                     cnt16, cnt4, lock16, lock4);
        end
    endtask

    task automatic test_clr();
        logic b;
        gen_bit(b);
        tick(1'b1, ~b, 1'b1);
        n_chk++;
        if (err16 !== 1'b1 || cnt16 !== 16'd0 || cnt4 !== 4'd0 || lock16 !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_err: err=%b cnt=%0d cnt4=%0d lock=%b want 1/0/0/1",
                     err16, cnt16, cnt4, lock16);
        end
        for (int k = 0; k < 5; k++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
        end
        gen_bit(b);
        tick(1'b1, ~b, 1'b0);
        n_chk++;
        if (cnt16 !== 16'd1 || cnt4 !== 4'd1 || err16 !== 1'b1) begin
            n_fail++;
            $display("FAIL post_clr: cnt=%0d cnt4=%0d err=%b want 1/1/1",
                     cnt16, cnt4, err16);
        end
    endtask

    task automatic test_reset_locked();
        logic b;
        n_chk++;
        if (lock16 !== 1'b1) begin
            n_fail++;
            $display("FAIL prereset_lock: lock=%b want 1", lock16);
        end
        RST = 1'b0;
        gen_bit(b);
        tick(1'b1, ~b, 1'b0);
        RST = 1'b1;
        n_chk++;
        if (lock16 !== 1'b0 || cnt16 !== 16'd0 || err16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_locked: lock=%b cnt=%0d err=%b want 0/0/0",
                     lock16, cnt16, err16);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst();
        test_ena_gaps();
        test_lockup_guard();
        test_saturation();
        test_clr();
        test_reset_locked();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
